// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage <-> MDU handshake bundle.
// master (E stage / bench): drives start, op, src_a, src_b, flush; sees ready, busy, hilo_we, hi_out, lo_out.
// slave (mdu_sequencer): the reverse.
interface mdu_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output start, op, src_a, src_b, flush, input ready, busy, hilo_we, hi_out, lo_out);
  modport slave (input start, op, src_a, src_b, flush, output ready, busy, hilo_we, hi_out, lo_out);
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer producing a HI/LO pair with a one-cycle write strobe.
// Ports: clk, rst (async, active-high); bus (mdu_sequencer_if.slave):
//   start/op/src_a/src_b/flush in; ready (0 = stall E), busy, hilo_we, hi_out, lo_out out.
// Option: define MDU_FAST_MUL_EN for single-cycle multiplies straight from IDLE.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  mdu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic isDivReg, negQ, negR;
  logic [WIDTH:0] acc;
  logic [WIDTH-1:0] mq, divisor, hiReg, loReg;
  logic [CNT_W-1:0] cnt;
  logic isDiv, aNeg, bNeg, divOk;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0] mulSum, shifted;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prodFix;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;
`endif
  always_comb begin
    isDiv = bus.op[1];
    aNeg = !bus.op[0] & bus.src_a[WIDTH-1];
    bNeg = !bus.op[0] & bus.src_b[WIDTH-1];
    absA = aNeg ? -bus.src_a : bus.src_a;
    absB = bNeg ? -bus.src_b : bus.src_b;
    // acc holds at most WIDTH significant bits during multiply, so the sum cannot overflow WIDTH+1 bits
    mulSum = acc + (mq[0] ? {1'b0, divisor} : '0);
    shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
    // one extra bit so a borrow is distinguishable from a large partial remainder
    diff = {1'b0, shifted} - {2'b0, divisor};
    divOk = !diff[WIDTH+1];
    prodFix = negQ ? -{acc[WIDTH-1:0], mq} : {acc[WIDTH-1:0], mq};
`ifdef MDU_FAST_MUL_EN
    fastProd = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};
    fastProd = (aNeg ^ bNeg) ? -fastProd : fastProd;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      isDivReg <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      acc <= '0;
      mq <= '0;
      divisor <= '0;
      cnt <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          isDivReg <= isDiv;
          negQ <= aNeg ^ bNeg;
          negR <= aNeg;
          acc <= '0;
          cnt <= '0;
          mq <= absA;
          divisor <= absB;
          if (isDiv && bus.src_b == '0) begin
            hiReg <= bus.src_a;
            loReg <= '1;
            state <= DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!isDiv) begin
            {hiReg, loReg} <= fastProd;
            state <= DONE;
          end
`endif
          else state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= isDivReg ? (divOk ? diff[WIDTH:0] : shifted) : {1'b0, mulSum[WIDTH:1]};
          mq <= isDivReg ? {mq[WIDTH-2:0], divOk} : {mulSum[0], mq[WIDTH-1:1]};
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          loReg <= isDivReg ? (negQ ? -mq : mq) : prodFix[WIDTH-1:0];
          hiReg <= isDivReg ? (negR ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prodFix[2*WIDTH-1:WIDTH];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ready = (state == IDLE && !bus.start) || state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.hilo_we = state == DONE && !bus.flush;
  assign bus.hi_out = hiReg;
  assign bus.lo_out = loReg;
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the execute stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operations from the E stage, iterates a shared shift-add / restoring-divide datapath, and returns a HI/LO pair with a one-cycle write strobe. While it works, it holds `ready` low; the hazard unit uses `ready` as `MDUReadyE` to stall F/D/E.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `CNT_W`, 6, iteration counter width; must satisfy 2^`CNT_W` > `WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  E-stage instruction is an MDU op; sampled only in IDLE.
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with `start`.
- `src_a`  in  WIDTH  rs operand (multiplicand / dividend).
- `src_b`  in  WIDTH  rt operand (multiplier / divisor).
- `flush`  in  1  abort the operation in flight; no HI/LO write.
- `ready`  out  1  0 = stall E stage.
- `busy`  out  1  1 in any state except IDLE.
- `hilo_we`  out  1  one-cycle strobe; HI/LO register captures `hi_out`/`lo_out`.
- `hi_out`  out  WIDTH  MULT: upper product; DIV: remainder.
- `lo_out`  out  WIDTH  MULT: lower product; DIV: quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: if `start` & !`flush`, latch `op`, take |a| and |b| (signed ops only; unsigned ops pass operands through), record result signs, clear acc/cnt, and go to RUN. A divide with `src_b`==0 goes directly to DONE with `lo_out`=all ones and `hi_out`=`src_a`.
- RUN: one iteration per cycle. Multiply: shift-add on {acc,mq}. Divide: restoring shift-subtract. `cnt` increments; after iteration `WIDTH` (cnt==WIDTH-1), go to FIX.
- FIX: apply signs. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend. Go to DONE.
- DONE: `hilo_we`=1 and `ready`=1. Unconditionally go to IDLE next cycle.
- `ready` = (IDLE & !`start`) | DONE. It is combinational, so the cycle in which `start` is first asserted already stalls.
- `flush` in any state: go to IDLE next edge with no `hilo_we`. `flush` has priority over `start` and over the DONE write. In DONE, `hilo_we` is gated by !`flush`.
- Arithmetic is unsigned internally on `WIDTH`+1 bits for the divide remainder. Negating the most negative number wraps (two's complement), matching MIPS (DIV 0x80000000 / -1 gives LO=0x80000000, HI=0).
- `hi_out`/`lo_out` hold their last value outside DONE.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `hilo_we`=0, `hi_out`=0, `lo_out`=0, cnt=0.
- Iterative latency: `start` seen in IDLE at cycle 0, RUN cycles 1..WIDTH, FIX cycle WIDTH+1, DONE cycle WIDTH+2. For WIDTH=32, `hilo_we` is high in cycle 34 and `ready` is low for cycles 0..33.
- Divide-by-zero: DONE in cycle 1.
- Back-to-back ops: a new `start` is accepted only in IDLE. The minimum gap is DONE→IDLE; the pipeline advances past the first op in the DONE cycle.
- `rst` mid-operation: immediate return to reset values; no `hilo_we`.

## Configuration
- `MDU_FAST_MUL_EN` defined: MULT/MULTU compute a single-cycle 2·WIDTH product from IDLE and go straight to DONE (`hilo_we` in cycle 1, `ready` low only in cycle 0). Divides are unchanged.
- Undefined: every multiply uses the iterative RUN/FIX path, with latency WIDTH+2.

## Test plan
- MULT a=-3 (0xFFFFFFFD), b=7 → `hilo_we` in cycle 34 (cycle 1 with `MDU_FAST_MUL_EN`), HI=0xFFFFFFFF, LO=0xFFFFFFEB; `ready` low in cycles 0..33.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU a=5, b=0 → DONE in cycle 1, LO=0xFFFFFFFF, HI=5.
- `flush` in RUN cycle 10 → IDLE at cycle 11, `ready`=1, no `hilo_we`. A new `start` in cycle 11 completes normally.
- `rst` pulsed during RUN → all outputs return to reset values asynchronously. `flush` asserted in DONE → `hilo_we` stays 0.
